switch_buffer: RTL and testbench
================================

# switch_buffer

Shared flit buffer of one switch, directly downstream of the switch arbiter. It captures the flit on the arbiter-selected input port when the arbiter issues a write request, and stores it with its arbiter-chosen output port. It presents the oldest flit to that output port with a one-hot valid, and returns full/empty status to the arbiter. Circular FIFO storage with a registered occupancy count and a sticky error flag.

## Interface

Parameters:
- PORTS_NUM, 4: number of network ports. Port indices 0..PORTS_NUM-1 are network ports; index PORTS_NUM is the local port, giving PORTS_NUM+1 ports in total.
- DATA_SIZE, 32: flit width in bits.
- DEPTH, 4: buffer entries. Must be a power of two, ≥2.
- Derived PW = $clog2(PORTS_NUM+1): port index width. Derived CW = $clog2(DEPTH)+1: count width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- a_rst  in  1  reset, synchronous, active-high.
- data_in  in  (PORTS_NUM+1)*DATA_SIZE  input flits; port i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- wr_req  in  1  write request from arbiter.
- in_port  in  PW  index of the port whose flit is written.
- out_port  in  PW  destination port stored with the flit.
- r_ready_in  in  PORTS_NUM+1  per-port downstream ready.
- data_out  out  DATA_SIZE  head flit; 0 when empty.
- valid_out  out  PORTS_NUM+1  one-hot head destination; all 0 when empty.
- mem_is_full  out  1  count == DEPTH.
- mem_is_empty  out  1  count == 0.
- count  out  CW  current occupancy.
- err  out  1  sticky error flag.

## Operation

- Storage: DEPTH entries, each holding {dest[PW-1:0], flit[DATA_SIZE-1:0]}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0. Occupancy is held in count register.
- pop = !mem_is_empty && (valid_out & r_ready_in) != 0. This equals r_ready_in[head dest] while not empty.
- Write legality: legal when wr_req is high, in_port ≤ PORTS_NUM, out_port ≤ PORTS_NUM, and (!mem_is_full || pop).
- Legal write: entry[wr_ptr] ← {out_port, data_in[in_port]}, then wr_ptr+1.
- Illegal write:
  - No storage change.
  - err ← 1. Covers an out-of-range index, and wr_req while full with no pop.
- err clears only on a_rst.
- Pop: rd_ptr+1.
- count next value:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- Full with simultaneous pop and legal write: both happen; count stays DEPTH and mem_is_full stays 1.
- Empty: no pop is possible, and r_ready_in is ignored. There is no write-to-read bypass.
- mem_is_full, mem_is_empty, data_out and valid_out decode combinationally from registers (count, rd_ptr, storage). They carry no combinational path from inputs.
- valid_out[p] = !mem_is_empty && head dest == p.
- Reset (a_rst=1 at an edge):
  - wr_ptr=0, rd_ptr=0, count=0, err=0.
  - Outputs: mem_is_empty=1, mem_is_full=0, valid_out=0, data_out=0.
  - Storage contents need no reset.
  - Reset overrides any concurrent wr_req or pop at that edge.

## Timing

- Write latency: a flit written at edge N appears as head at N+1 when the buffer was empty at N. valid_out and data_out become valid after edge N.
- Pop takes effect at the edge where valid_out[p] & r_ready_in[p] is high. The next entry, or empty, is visible after that edge.
- Throughput: one write and one pop per cycle sustained.
- mem_is_full and mem_is_empty reflect post-edge count. The arbiter sees them the cycle after the write that changed them.
- Reset mid-stream discards all stored flits in one cycle. Outputs read the reset values from the next cycle on.

## Test plan

- Reset, then write once with wr_req=1, in_port=2, out_port=4, data_in lane 2=0xDEADBEEF.
  - Required response: next cycle valid_out=5'b10000, data_out=0xDEADBEEF, count=1, mem_is_empty=0.
  - Then r_ready_in[4]=1 for one cycle → empty, valid_out=0, data_out=0.
- Fill: 4 consecutive writes of 0x1..0x4 to out_port 0, with r_ready_in=0.
  - Required response: count=4, mem_is_full=1.
  - A 5th wr_req → err=1, count=4, head still 0x1.
- Full with simultaneous write 0x5 and r_ready_in[0]=1.
  - Required response: count stays 4.
  - Subsequent pops yield 0x2, 0x3, 0x4, 0x5. This exercises pointer wrap-around.
- Head destined for port 1 with r_ready_in=5'b11101.
  - Required response: no pop, count unchanged.
  - Then r_ready_in=5'b00010 → pop.
- Out-of-range index: wr_req with in_port=5 or out_port=7 (PORTS_NUM=4).
  - Required response: no write, count unchanged, err=1. err persists until a_rst.
- Reset asserted mid-stream with count=3 and wr_req=1.
  - Required response: next cycle count=0, mem_is_empty=1, err=0, valid_out=0.

Source files
------------

// File: rtl/switch_buffer.sv
// Shared flit buffer behind the switch arbiter: circular FIFO of {dest, flit}
// entries with a one-hot head valid, occupancy count and sticky error flag.

module switch_buffer_lane #(
  parameter int PW      = 3,
  parameter int PORT_ID = 0
) (
  input  logic          head_vld,
  input  logic [PW-1:0] head_dest,
  input  logic          ready,
  output logic          valid,
  output logic          fire
);
  assign valid = head_vld && (head_dest == PW'(PORT_ID));
  assign fire  = valid && ready;
endmodule

module switch_buffer #(
  parameter int PORTS_NUM = 4,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 4,
  localparam int NP = PORTS_NUM + 1,
  localparam int PW = $clog2(PORTS_NUM + 1),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic [NP*DATA_SIZE-1:0] data_in,
  input  logic                    wr_req,
  input  logic [PW-1:0]           in_port,
  input  logic [PW-1:0]           out_port,
  input  logic [NP-1:0]           r_ready_in,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic [NP-1:0]           valid_out,
  output logic                    mem_is_full,
  output logic                    mem_is_empty,
  output logic [CW-1:0]           count,
  output logic                    err
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][PW-1:0]        dest_mem;
  logic [DEPTH-1:0][DATA_SIZE-1:0] flit_mem;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [NP-1:0]                   fire;
  logic [DATA_SIZE-1:0]            wr_flit;
  logic                            pop, idx_ok, wr_ok;

  assign mem_is_empty = (count == '0);
  assign mem_is_full  = (count == CW'(DEPTH));
  assign data_out     = mem_is_empty ? '0 : flit_mem[rd_ptr];

  for (genvar p = 0; p < NP; p++) begin : g_lane
    switch_buffer_lane #(.PW(PW), .PORT_ID(p)) u_lane (
      .head_vld  (!mem_is_empty),
      .head_dest (dest_mem[rd_ptr]),
      .ready     (r_ready_in[p]),
      .valid     (valid_out[p]),
      .fire      (fire[p])
    );
  end

  assign pop = |fire;

  // Mux by comparison so an out-of-range in_port never indexes past data_in.
  always_comb begin
    wr_flit = '0;
    for (int i = 0; i < NP; i++)
      if (in_port == PW'(i)) wr_flit = data_in[i*DATA_SIZE +: DATA_SIZE];
  end

  assign idx_ok = (in_port <= PW'(PORTS_NUM)) && (out_port <= PW'(PORTS_NUM));
  assign wr_ok  = wr_req && idx_ok && (!mem_is_full || pop);

  always_ff @(posedge clk) begin
    if (a_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && !wr_ok) err <= 1'b1;
    end
  end

  // Storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!a_rst && wr_ok) begin
      dest_mem[wr_ptr] <= out_port;
      flit_mem[wr_ptr] <= wr_flit;
    end
  end
endmodule

// File: tb/tb_switch_buffer.sv
// Directed bench for switch_buffer: queue model checked every cycle plus
// hand-computed literal expectations at the key points.

module tb_switch_buffer;
  localparam int NP = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic             clk = 0;
  logic             a_rst = 0;
  logic [NP*DW-1:0] data_in = '0;
  logic             wr_req = 0;
  logic [2:0]       in_port = '0, out_port = '0;
  logic [NP-1:0]    r_ready_in = '0;
  logic [DW-1:0]    data_out;
  logic [NP-1:0]    valid_out;
  logic             mem_is_full, mem_is_empty, err;
  logic [2:0]       count;

  switch_buffer #(.PORTS_NUM(4), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst(a_rst), .data_in(data_in), .wr_req(wr_req),
    .in_port(in_port), .out_port(out_port), .r_ready_in(r_ready_in),
    .data_out(data_out), .valid_out(valid_out), .mem_is_full(mem_is_full),
    .mem_is_empty(mem_is_empty), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of pending flits in arrival order.
  typedef struct packed { logic [2:0] dest; logic [DW-1:0] flit; } ent_t;
  ent_t q[$];
  bit   m_err = 0;
  bit   chk_en = 0;

  always @(posedge clk) begin
    if (a_rst) begin
      q.delete();
      m_err  = 0;
      chk_en = 1;
    end else if (chk_en) begin
      bit   do_pop, ok;
      ent_t e;
      do_pop = (q.size() > 0) && r_ready_in[q[0].dest];
      ok = wr_req && (in_port <= 4) && (out_port <= 4) && ((q.size() < DEPTH) || do_pop);
      if (ok) begin
        e.dest = out_port;
        e.flit = data_in[int'(in_port)*DW +: DW];
      end
      if (do_pop) void'(q.pop_front());
      if (ok) q.push_back(e);
      else if (wr_req) m_err = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count", 64'(count), 64'(q.size()));
      check("m_empty", 64'(mem_is_empty), 64'(q.size() == 0));
      check("m_full",  64'(mem_is_full),  64'(q.size() == DEPTH));
      check("m_err",   64'(err), 64'(m_err));
      check("m_data",  64'(data_out), (q.size() > 0) ? 64'(q[0].flit) : 64'd0);
      check("m_valid", 64'(valid_out), (q.size() > 0) ? 64'(5'b1 << q[0].dest) : 64'd0);
    end
  end

  // One clock: drive inputs, take the edge, return at the next falling edge.
  task automatic cyc(input logic rst, input logic wr, input logic [2:0] ip,
                     input logic [2:0] op, input logic [NP-1:0] rdy, input logic [DW-1:0] d);
    a_rst = rst; wr_req = wr; in_port = ip; out_port = op; r_ready_in = rdy;
    for (int i = 0; i < NP; i++)
      data_in[i*DW +: DW] = (int'(ip) == i) ? d : ~d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [NP-1:0] rdy);
    cyc(0, 0, 0, 0, rdy, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, '0, 0);
    cyc(1, 1, 0, 0, '1, 32'h77);
    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(mem_is_empty), 1);
    check("rst_full",  64'(mem_is_full), 0);
    check("rst_valid", 64'(valid_out), 0);
    check("rst_data",  64'(data_out), 0);
    check("rst_err",   64'(err), 0);

    cyc(0, 1, 2, 4, '0, 32'hDEADBEEF);
    check("w1_valid", 64'(valid_out), 64'h10);
    check("w1_data",  64'(data_out), 64'hDEADBEEF);
    check("w1_count", 64'(count), 1);
    check("w1_empty", 64'(mem_is_empty), 0);
    idle(5'b10000);
    check("p1_empty", 64'(mem_is_empty), 1);
    check("p1_valid", 64'(valid_out), 0);
    check("p1_data",  64'(data_out), 0);
    idle(5'b11111);
    check("empty_ign", 64'(count), 0);

    for (int k = 1; k <= 4; k++) cyc(0, 1, 0, 0, '0, 32'(k));
    check("fill_count", 64'(count), 4);
    check("fill_full",  64'(mem_is_full), 1);
    cyc(0, 1, 0, 0, '0, 32'h99);
    check("ovf_err",   64'(err), 1);
    check("ovf_count", 64'(count), 4);
    check("ovf_head",  64'(data_out), 1);

    cyc(0, 1, 0, 0, 5'b00001, 32'h5);
    check("fwp_count", 64'(count), 4);
    check("fwp_full",  64'(mem_is_full), 1);
    check("fwp_head",  64'(data_out), 2);
    for (int k = 3; k <= 5; k++) begin
      idle(5'b00001);
      check("wrap_head", 64'(data_out), 64'(k));
    end
    idle(5'b00001);
    check("wrap_empty", 64'(mem_is_empty), 1);
    check("err_sticky", 64'(err), 1);

    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 1, 3, 1, '0, 32'h11);
    idle(5'b11101);
    check("blk_count", 64'(count), 1);
    check("blk_valid", 64'(valid_out), 64'h02);
    idle(5'b00010);
    check("unblk_empty", 64'(mem_is_empty), 1);

    cyc(0, 1, 5, 0, '0, 32'h55);
    check("oor_in_err",   64'(err), 1);
    check("oor_in_count", 64'(count), 0);
    cyc(1, 0, 0, 0, '0, 0);
    check("rst_clr_err", 64'(err), 0);
    cyc(0, 1, 1, 7, '0, 32'h66);
    check("oor_out_err",   64'(err), 1);
    check("oor_out_count", 64'(count), 0);
    idle('0); idle('0);
    check("oor_persist", 64'(err), 1);

    // Sustained write+pop with rotating destinations and ready patterns.
    for (int k = 0; k < 24; k++)
      cyc(0, (k % 5) != 4, 3'(k % 5), 3'((k * 3) % 5), 5'((k * 7) % 32), 32'h100 + 32'(k));

    cyc(1, 0, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 3'(k), 2, '0, 32'hA0 + 32'(k));
    cyc(0, 1, 6, 2, '0, 32'hBAD);
    check("pre_count", 64'(count), 3);
    check("pre_err",   64'(err), 1);
    cyc(1, 1, 0, 2, 5'b00100, 32'hCC);
    check("mid_count", 64'(count), 0);
    check("mid_empty", 64'(mem_is_empty), 1);
    check("mid_err",   64'(err), 0);
    check("mid_valid", 64'(valid_out), 0);
    idle('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
